// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its fault checker.
package lsu_pkg;

  // Transaction sequencing: accept in IDLE, touch the RAM in ACCESS, hold the answer in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Fault cause as reported on respCause; encoding is visible to software.
  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_ILLEGAL    = 2'b01,
    CAUSE_MISALIGNED = 2'b10,
    CAUSE_RANGE      = 2'b11
  } lsu_cause_e;

  // funct3 access encodings (stores reuse LB/LH/LW for SB/SH/SW).
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Request fields captured at accept time.
  typedef struct packed {
    logic        write;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Number of bytes touched by an access; the sign bit (ctrl[2]) does not matter.
  function automatic logic [2:0] access_bytes(input logic [2:0] ctrl);
    logic [2:0] n;
    case (ctrl[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_check.sv
// Combinational fault decode for a latched load/store request.
module lsu_check
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 1024
) (
  input  logic        write,
  input  logic [2:0]  ctrl,
  input  logic [31:0] addr,
  output lsu_cause_e  cause
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] last_byte;

  // Evaluate each fault class independently, then report only the most severe.
  always_comb begin
    // 011/110/111 are unused encodings; unsigned variants make no sense for stores.
    illegal = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) ||
              (write && ctrl[2]);

    misaligned = ((ctrl[1:0] == 2'b01) && addr[0]) ||
                 ((ctrl[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // 33-bit sum so an address near 2^32 cannot wrap back into the legal window.
    last_byte    = {1'b0, addr} + {30'd0, access_bytes(ctrl)} - 33'd1;
    out_of_range = (last_byte >= 33'(RAM_BYTES));

    if (illegal) begin
      cause = CAUSE_ILLEGAL;
    end else if (misaligned) begin
      cause = CAUSE_MISALIGNED;
    end else if (out_of_range) begin
      cause = CAUSE_RANGE;
    end else begin
      cause = CAUSE_NONE;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a byte-addressed data RAM.
// Handshakes: a transfer happens on a rising Clock edge where valid and ready are both 1;
// reqValid/req* must hold until reqReady, and respValid/resp* hold until respReady.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 1024
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqCtrl,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respData,
  output logic        respFault,
  output logic [1:0]  respCause,
  output logic        writeRam,
  output logic [2:0]  ctrl,
  output logic [31:0] address,
  output logic [31:0] wData,
  input  logic [31:0] rData
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_fault_q, resp_fault_d;
  lsu_cause_e  resp_cause_q, resp_cause_d;

  lsu_cause_e  cause;
  logic        req_ok;

  // Fault decode always looks at the latched request, so it is stable through ACCESS.
  lsu_check #(
    .RAM_BYTES(RAM_BYTES)
  ) u_check (
    .write(req_q.write),
    .ctrl (req_q.ctrl),
    .addr (req_q.addr),
    .cause(cause)
  );

  assign req_ok = (cause == CAUSE_NONE);

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  // Next-state and register-load logic; everything holds unless a step below updates it.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    resp_cause_d = resp_cause_q;

    case (state_q)
      IDLE: begin
        if (reqValid) begin
          req_d.write = reqWrite;
          req_d.ctrl  = reqCtrl;
          req_d.addr  = reqAddr;
          req_d.wdata = reqWData;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM formats the read by ctrl, so rData is already size/sign adjusted.
        resp_data_d  = (!req_q.write && req_ok) ? rData : 32'd0;
        resp_fault_d = !req_ok;
        resp_cause_d = cause;
        state_d      = RESP;
      end
      RESP: begin
        if (respReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state; writeRam lives for the single ACCESS cycle.
  always_comb begin
    reqReady  = (state_q == IDLE);
    respValid = (state_q == RESP);
    writeRam  = (state_q == ACCESS) && req_q.write && req_ok;
    respData  = resp_data_q;
    respFault = resp_fault_q;
    respCause = resp_cause_q;
    ctrl      = req_q.ctrl;
    address   = req_q.addr;
    wData     = req_q.wdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences,
// then randomized requests checked against a byte-array reference model.
module tb_load_store_unit;

  localparam int RB = 1024;

  logic        Clock;
  logic        nReset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  reqCtrl;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respData;
  logic        respFault;
  logic [1:0]  respCause;
  logic        writeRam;
  logic [2:0]  ctrl;
  logic [31:0] address;
  logic [31:0] wData;
  logic [31:0] rData;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int wr_cnt  = 0;

  load_store_unit #(.RAM_BYTES(RB)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .reqWrite (reqWrite),
    .reqCtrl  (reqCtrl),
    .reqAddr  (reqAddr),
    .reqWData (reqWData),
    .respValid(respValid),
    .respReady(respReady),
    .respData (respData),
    .respFault(respFault),
    .respCause(respCause),
    .writeRam (writeRam),
    .ctrl     (ctrl),
    .address  (address),
    .wData    (wData),
    .rData    (rData)
  );

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model seen by the DUT ----------------
  logic [7:0] ram [RB];
  logic [7:0] rb0, rb1, rb2, rb3;

  initial for (int i = 0; i < RB; i++) ram[i] = 8'h00;

  // Byte-lane write on the strobe; also counts strobe cycles.
  always @(posedge Clock) begin
    if (writeRam) begin
      wr_cnt++;
      for (int k = 0; k < 4; k++) begin
        if ((k < 1 || ctrl[1:0] != 2'b00) && (k < 2 || ctrl[1:0] == 2'b10) &&
            ({1'b0, address} + 33'(k) < 33'(RB)))
          ram[address[9:0] + k[9:0]] = wData[8*k +: 8];
      end
    end
  end

  always_comb begin
    rb0 = ({1'b0, address}          < 33'(RB)) ? ram[address[9:0]]         : 8'h00;
    rb1 = ({1'b0, address} + 33'd1 < 33'(RB)) ? ram[address[9:0] + 10'd1] : 8'h00;
    rb2 = ({1'b0, address} + 33'd2 < 33'(RB)) ? ram[address[9:0] + 10'd2] : 8'h00;
    rb3 = ({1'b0, address} + 33'd3 < 33'(RB)) ? ram[address[9:0] + 10'd3] : 8'h00;
    case (ctrl)
      3'b000:  rData = {{24{rb0[7]}}, rb0};
      3'b100:  rData = {24'h0, rb0};
      3'b001:  rData = {{16{rb1[7]}}, rb1, rb0};
      3'b101:  rData = {16'h0, rb1, rb0};
      3'b010:  rData = {rb3, rb2, rb1, rb0};
      default: rData = 32'h0;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [RB];
  initial for (int i = 0; i < RB; i++) ref_mem[i] = 8'h00;

  function automatic int ref_size(input logic [2:0] c);
    int m;
    m = int'(c) % 4;
    return (m == 0) ? 1 : (m == 1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] ref_cause(input logic w, input logic [2:0] c, input logic [31:0] a);
    int sz;
    if (c == 3 || c == 6 || c == 7 || (w && c >= 4)) return 2'b01;
    sz = ref_size(c);
    if (longint'(a) % sz != 0) return 2'b10;
    if (longint'(a) + sz > RB) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
    longint v;
    int sz;
    sz = ref_size(c);
    v  = 0;
    for (int k = 0; k < sz; k++) v += longint'(ref_mem[int'(a) + k]) << (8 * k);
    if (c < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < ref_size(c); k++) ref_mem[int'(a) + k] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, check the ACCESS view, latency, response, backpressure and write count.
  task automatic run_req(input string tag, input logic w, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] e_data, input logic e_fault,
                         input logic [1:0] e_cause, input int stall);
    int n;
    int wr0;
    int exp_wr;
    n = 0;
    while (!reqReady && n < 20) begin @(negedge Clock); n++; end
    chk($sformatf("%s reqReady_idle", tag), reqReady, 1);
    reqValid = 1'b1; reqWrite = w; reqCtrl = c; reqAddr = a; reqWData = d;
    wr0 = wr_cnt;
    exp_wr = (w && e_cause == 2'b00) ? 1 : 0;
    @(negedge Clock);
    reqValid = 1'b0; reqWrite = 1'($urandom); reqCtrl = 3'($urandom);
    reqAddr = $urandom; reqWData = $urandom;
    chk($sformatf("%s address", tag), address, a);
    chk($sformatf("%s ctrl", tag), {29'd0, ctrl}, {29'd0, c});
    chk($sformatf("%s wData", tag), wData, d);
    chk($sformatf("%s reqReady_busy", tag), reqReady, 0);
    chk($sformatf("%s writeRam", tag), writeRam, exp_wr);
    n = 1;
    while (!respValid && n < 20) begin @(negedge Clock); n++; end
    chk($sformatf("%s latency", tag), n, 2);
    chk($sformatf("%s respData", tag), respData, e_data);
    chk($sformatf("%s respFault", tag), respFault, e_fault);
    chk($sformatf("%s respCause", tag), respCause, e_cause);
    for (int s = 0; s < stall; s++) begin
      @(negedge Clock);
      chk($sformatf("%s stall%0d respValid", tag, s), respValid, 1);
      chk($sformatf("%s stall%0d respData", tag, s), respData, e_data);
      chk($sformatf("%s stall%0d respCause", tag, s), {respFault, respCause}, {e_fault, e_cause});
      chk($sformatf("%s stall%0d reqReady", tag, s), reqReady, 0);
    end
    respReady = 1'b1;
    @(negedge Clock);
    respReady = 1'b0;
    chk($sformatf("%s respValid_done", tag), respValid, 0);
    chk($sformatf("%s reqReady_after", tag), reqReady, 1);
    chk($sformatf("%s write_count", tag), wr_cnt - wr0, exp_wr);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w;
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e_data;
    logic        e_fault;
    logic [1:0]  e_cause;
    int          stall;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] e_data, input logic [1:0] e_cause, input int stall);
    vec_t v;
    v.w = w; v.c = c; v.a = a; v.d = d; v.e_data = e_data;
    v.e_fault = (e_cause != 2'b00); v.e_cause = e_cause; v.stall = stall;
    tbl.push_back(v);
  endtask

  initial begin
    logic        w;
    logic [2:0]  c;
    logic [31:0] a, d, e;
    logic [1:0]  cs;
    int          sel;

    nReset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqCtrl = 3'd0;
    reqAddr = 32'd0; reqWData = 32'd0; respReady = 1'b0;

    // Reset values
    repeat (2) @(negedge Clock);
    chk("rst reqReady", reqReady, 1);
    chk("rst respValid", respValid, 0);
    chk("rst writeRam", writeRam, 0);
    chk("rst respData", respData, 0);
    chk("rst resp_fault_cause", {respFault, respCause}, 0);
    chk("rst address", address, 0);
    chk("rst ctrl_wData", {ctrl, wData}, 0);
    nReset = 1'b1;
    @(negedge Clock);

    //   w     ctrl    addr          wdata          exp data      cause stall
    add(1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        2'b00, 0);
    add(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 2'b00, 0);
    add(1'b1, 3'b000, 32'h3,        32'h00000080, 32'h0,        2'b00, 0);
    add(1'b0, 3'b000, 32'h3,        32'h0,        32'hFFFFFF80, 2'b00, 0);
    add(1'b0, 3'b100, 32'h3,        32'h0,        32'h00000080, 2'b00, 0);
    add(1'b0, 3'b010, 32'h2,        32'h0,        32'h0,        2'b10, 0);
    add(1'b1, 3'b001, 32'h3FF,      32'h1234,     32'h0,        2'b10, 0);
    add(1'b0, 3'b010, 32'h3FC,      32'h0,        32'h0,        2'b00, 0);
    add(1'b0, 3'b010, 32'h400,      32'h0,        32'h0,        2'b11, 0);
    add(1'b0, 3'b011, 32'h0,        32'h0,        32'h0,        2'b01, 0);
    add(1'b1, 3'b100, 32'h4,        32'h55,       32'h0,        2'b01, 0);
    add(1'b1, 3'b010, 32'h3FC,      32'h12345678, 32'h0,        2'b00, 0);
    add(1'b0, 3'b001, 32'h3FE,      32'h0,        32'h00001234, 2'b00, 0);
    add(1'b1, 3'b001, 32'h3FE,      32'h0000A5F0, 32'h0,        2'b00, 0);
    add(1'b0, 3'b101, 32'h3FE,      32'h0,        32'h0000A5F0, 2'b00, 0);
    add(1'b0, 3'b001, 32'h3FE,      32'h0,        32'hFFFFA5F0, 2'b00, 0);
    add(1'b0, 3'b000, 32'h3FF,      32'h0,        32'hFFFFFFA5, 2'b00, 0);
    add(1'b0, 3'b010, 32'h3FD,      32'h0,        32'h0,        2'b10, 0);
    add(1'b0, 3'b000, 32'h400,      32'h0,        32'h0,        2'b11, 0);
    add(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        2'b11, 0);
    add(1'b1, 3'b111, 32'h1,        32'h77,       32'h0,        2'b01, 0);
    add(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 2'b00, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      run_req($sformatf("vec%0d", i), tbl[i].w, tbl[i].c, tbl[i].a, tbl[i].d,
              tbl[i].e_data, tbl[i].e_fault, tbl[i].e_cause, tbl[i].stall);
      if (tbl[i].w && tbl[i].e_cause == 2'b00) ref_store(tbl[i].c, tbl[i].a, tbl[i].d);
    end

    // Back-to-back: request held valid in the handshake cycle is taken the cycle after.
    reqValid = 1'b1; reqWrite = 1'b0; reqCtrl = 3'b010; reqAddr = 32'h10;
    @(negedge Clock); reqValid = 1'b0;
    @(negedge Clock);
    chk("b2b first respValid", respValid, 1);
    respReady = 1'b1; reqValid = 1'b1; reqAddr = 32'h3FC;
    @(negedge Clock);
    respReady = 1'b0;
    chk("b2b reqReady", reqReady, 1);
    chk("b2b not yet latched", address, 32'h10);
    @(negedge Clock);
    reqValid = 1'b0;
    chk("b2b second latched", address, 32'h3FC);
    @(negedge Clock);
    chk("b2b second data", respData, ref_load(3'b010, 32'h3FC));
    respReady = 1'b1;
    @(negedge Clock);
    respReady = 1'b0;

    // Reset during ACCESS of SW @0x20: no write, no response.
    sel = wr_cnt;
    reqValid = 1'b1; reqWrite = 1'b1; reqCtrl = 3'b010; reqAddr = 32'h20; reqWData = 32'hCAFEF00D;
    @(negedge Clock);
    reqValid = 1'b0;
    chk("rstmid writeRam_pre", writeRam, 1);
    nReset = 1'b0;
    #1;
    chk("rstmid writeRam", writeRam, 0);
    chk("rstmid respValid", respValid, 0);
    chk("rstmid reqReady", reqReady, 1);
    chk("rstmid address", address, 0);
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    chk("rstmid no_write", wr_cnt - sel, 0);
    chk("rstmid respValid_after", respValid, 0);
    chk("rstmid reqReady_after", reqReady, 1);
    run_req("rstmid readback", 1'b0, 3'b010, 32'h20, 32'h0, ref_load(3'b010, 32'h20), 1'b0, 2'b00, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 250; i++) begin
      w   = 1'($urandom);
      c   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, RB + 7));
      else if (sel == 7) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else               a = $urandom;
      d  = $urandom;
      cs = ref_cause(w, c, a);
      e  = (!w && cs == 2'b00) ? ref_load(c, a) : 32'h0;
      run_req($sformatf("rnd%0d", i), w, c, a, d, e, cs != 2'b00, cs, $urandom_range(0, 3));
      if (w && cs == 2'b00) ref_store(c, a, d);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    // Whole-memory agreement between the DUT-written RAM and the reference.
    sel = 0;
    for (int i = 0; i < RB; i++) if (ram[i] !== ref_mem[i]) sel++;
    chk("final ram_diff_bytes", sel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
